// File: rtl/regfile_mp_if.sv
// Issue/writeback bundle for the multi-port register file. The issue stage drives
// the "master" side. The register file implements the "slave" side.
interface regfile_mp_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1
);
   localparam int AW = $clog2(NREGS);

   logic                     stall_i;
   logic                     flush_i;
   logic [NUM_WR-1:0]        wr_en_i;
   logic [NUM_WR*AW-1:0]     wr_addr_i;
   logic [NUM_WR*XLEN-1:0]   wr_data_i;
   logic                     alloc_en_i;
   logic [AW-1:0]            alloc_addr_i;
   logic [NUM_RD*AW-1:0]     rd_addr_i;
   logic [NUM_RD*XLEN-1:0]   rd_data_o;
   logic [NUM_RD-1:0]        rd_busy_o;
   logic [AW:0]              busy_cnt_o;

   modport master (
      output stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
             alloc_en_i, alloc_addr_i, rd_addr_i,
      input  rd_data_o, rd_busy_o, busy_cnt_o
   );

   modport slave (
      input  stall_i, flush_i, wr_en_i, wr_addr_i, wr_data_i,
             alloc_en_i, alloc_addr_i, rd_addr_i,
      output rd_data_o, rd_busy_o, busy_cnt_o
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard. x0 is always zero. x2 and x3 have parameterised reset values.
module regfile_mp_rdport #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NUM_WR = 1,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic [AW-1:0]                  addr,
   input  logic [NREGS-1:0][XLEN-1:0]     regs,
   input  logic [NREGS-1:0]               busy,
   input  logic [NUM_WR-1:0]              wr_qual,
   input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
   input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
   output logic [XLEN-1:0]                data,
   output logic                           busy_out
);
   // The ascending loop lets the highest-index matching write port win, as the array does.
   always_comb begin
      data     = regs[addr];
      busy_out = busy[addr];
      if (BYPASS != 0) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_qual[k] && (wr_addr[k] == addr)) begin
               data     = wr_data[k];
               busy_out = 1'b0;
            end
         end
      end
      if (addr == '0) begin
         data     = '0;
         busy_out = 1'b0;
      end
   end
endmodule

module regfile_mp #(
   parameter int              XLEN    = 32,
   parameter int              NREGS   = 32,
   parameter int              NUM_RD  = 2,
   parameter int              NUM_WR  = 1,
   parameter int              BYPASS  = 1,
   parameter logic [XLEN-1:0] SP_INIT = 32'h200,
   parameter logic [XLEN-1:0] GP_INIT = 32'h100
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);
   localparam int AW = $clog2(NREGS);

   logic [NREGS-1:0][XLEN-1:0]   regs;
   logic [NREGS-1:0]             busy;
   logic [AW:0]                  busy_cnt;

   logic [NUM_WR-1:0][AW-1:0]    wr_addr;
   logic [NUM_WR-1:0][XLEN-1:0]  wr_data;
   logic [NUM_WR-1:0]            wr_qual;
   logic [NUM_RD-1:0][AW-1:0]    rd_addr;
   logic [NUM_RD-1:0][XLEN-1:0]  rd_data;
   logic [NUM_RD-1:0]            rd_busy;

   logic [NREGS-1:0]             wr_hit;
   logic [NREGS-1:0][XLEN-1:0]   wr_val;
   logic                         alloc_qual;
   logic [NREGS-1:0]             busy_nxt;

   // The packed layouts match the flat bus layout: port k is at [k*W +: W].
   assign wr_addr = bus.wr_addr_i;
   assign wr_data = bus.wr_data_i;
   assign rd_addr = bus.rd_addr_i;

   // Reset also disqualifies writes. A write that is pending during reset cannot bypass to a read.
   for (genvar k = 0; k < NUM_WR; k++) begin : g_wq
      assign wr_qual[k] = bus.wr_en_i[k] & ~bus.stall_i & ~rst & (wr_addr[k] != '0);
   end

   assign alloc_qual = bus.alloc_en_i & ~bus.stall_i & (bus.alloc_addr_i != '0);

   function automatic logic [XLEN-1:0] reset_val(input int r);
      if (r == 2)      return SP_INIT;
      else if (r == 3) return GP_INIT;
      else             return '0;
   endfunction

   function automatic logic [AW:0] popcnt(input logic [NREGS-1:0] v);
      logic [AW:0] s;
      s = '0;
      for (int i = 0; i < NREGS; i++) s = s + (AW+1)'(v[i]);
      return s;
   endfunction

   always_comb begin
      wr_hit = '0;
      wr_val = '0;
      for (int r = 1; r < NREGS; r++) begin
         for (int k = 0; k < NUM_WR; k++) begin
            if (wr_qual[k] && (wr_addr[k] == AW'(r))) begin
               wr_hit[r] = 1'b1;
               wr_val[r] = wr_data[k];
            end
         end
      end
   end

   // Flush beats a new allocation. A new allocation beats a completing write.
   always_comb begin
      busy_nxt = busy;
      for (int r = 1; r < NREGS; r++) begin
         if (bus.flush_i)
            busy_nxt[r] = 1'b0;
         else if (alloc_qual && (bus.alloc_addr_i == AW'(r)))
            busy_nxt[r] = 1'b1;
         else if (wr_hit[r])
            busy_nxt[r] = 1'b0;
      end
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= reset_val(r);
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (wr_hit[r]) regs[r] <= wr_val[r];
         end
         busy     <= busy_nxt;
         busy_cnt <= popcnt(busy_nxt);
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      regfile_mp_rdport #(
         .XLEN   (XLEN),
         .NREGS  (NREGS),
         .NUM_WR (NUM_WR),
         .BYPASS (BYPASS),
         .AW     (AW)
      ) u_rd (
         .addr     (rd_addr[i]),
         .regs     (regs),
         .busy     (busy),
         .wr_qual  (wr_qual),
         .wr_addr  (wr_addr),
         .wr_data  (wr_data),
         .data     (rd_data[i]),
         .busy_out (rd_busy[i])
      );
   end

   assign bus.rd_data_o  = rd_data;
   assign bus.rd_busy_o  = rd_busy;
   assign bus.busy_cnt_o = busy_cnt;
endmodule
